// File: rtl/mips_boot_controller.sv
// Boot controller for the single-cycle MIPS top.
// It streams a program into instruction memory, releases the CPU from reset,
// and then watches test_value until it matches the expected value or the
// cycle budget runs out.
module mips_boot_controller #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int MAX_WORDS  = 256,
    parameter int TIMEOUT    = 1000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   prog_len,
    input  logic [DATA_WIDTH-1:0] expected,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [DATA_WIDTH-1:0] imem_wdata,
    output logic                  cpu_reset_n,
    input  logic [DATA_WIDTH-1:0] test_value,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  fail
);

    // The cycle counter only has to reach TIMEOUT. It saturates at all-ones.
    localparam int CYC_W = $clog2(TIMEOUT + 1);
    localparam logic [CYC_W-1:0]    TIMEOUT_C = TIMEOUT[CYC_W-1:0];
    localparam logic [ADDR_WIDTH:0] LEN_MAX   = MAX_WORDS[ADDR_WIDTH:0];

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;

    state_e                state_q, state_d;
    logic                  s_ready_q, s_ready_d;
    logic                  imem_we_q, imem_we_d;
    logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
    logic [DATA_WIDTH-1:0] imem_wdata_q, imem_wdata_d;
    logic                  cpu_reset_n_q, cpu_reset_n_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  pass_q, pass_d;
    logic                  fail_q, fail_d;
    logic [ADDR_WIDTH:0]   word_cnt_q, word_cnt_d;
    logic [ADDR_WIDTH:0]   len_q, len_d;
    logic [DATA_WIDTH-1:0] exp_q, exp_d;
    logic [CYC_W-1:0]      cyc_q, cyc_d;
    logic [ADDR_WIDTH:0]   cnt_inc;

    assign cnt_inc = word_cnt_q + 1'b1;

    // Next-state and registered-output logic.
    always_comb begin
        state_d       = state_q;
        s_ready_d     = s_ready_q;
        imem_we_d     = 1'b0;
        imem_addr_d   = imem_addr_q;
        imem_wdata_d  = imem_wdata_q;
        cpu_reset_n_d = cpu_reset_n_q;
        busy_d        = busy_q;
        done_d        = done_q;
        pass_d        = pass_q;
        fail_d        = fail_q;
        word_cnt_d    = word_cnt_q;
        len_d         = len_q;
        exp_d         = exp_q;
        cyc_d         = cyc_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    pass_d = 1'b0;
                    fail_d = 1'b0;
                    done_d = 1'b0;
                    len_d  = prog_len;
                    exp_d  = expected;
                    if (prog_len != '0 && prog_len <= LEN_MAX) begin
                        word_cnt_d = '0;
                        s_ready_d  = 1'b1;
                        busy_d     = 1'b1;
                        state_d    = LOAD;
                    end else begin
                        // An illegal length fails at once. Memory and CPU are left alone.
                        fail_d  = 1'b1;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            LOAD: begin
                if (s_ready_q && s_valid) begin
                    imem_we_d    = 1'b1;
                    imem_addr_d  = word_cnt_q[ADDR_WIDTH-1:0];
                    imem_wdata_d = s_data;
                    word_cnt_d   = cnt_inc;
                    // Close the stream on the last word so no extra word is taken.
                    if (cnt_inc == len_q) s_ready_d = 1'b0;
                end else if (!s_ready_q) begin
                    // The final write is on the bus this cycle. Start the CPU after it.
                    cpu_reset_n_d = 1'b1;
                    cyc_d         = {{(CYC_W-1){1'b0}}, 1'b1};
                    state_d       = RUN;
                end
            end
            RUN: begin
                if (test_value == exp_q) begin
                    pass_d        = 1'b1;
                    done_d        = 1'b1;
                    busy_d        = 1'b0;
                    cpu_reset_n_d = 1'b0;
                    state_d       = DONE;
                end else if (cyc_q == TIMEOUT_C) begin
                    fail_d        = 1'b1;
                    done_d        = 1'b1;
                    busy_d        = 1'b0;
                    cpu_reset_n_d = 1'b0;
                    state_d       = DONE;
                end else if (cyc_q != '1) begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers. A synchronous reset clears everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            s_ready_q     <= 1'b0;
            imem_we_q     <= 1'b0;
            imem_addr_q   <= '0;
            imem_wdata_q  <= '0;
            cpu_reset_n_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            fail_q        <= 1'b0;
            word_cnt_q    <= '0;
            len_q         <= '0;
            exp_q         <= '0;
            cyc_q         <= '0;
        end else begin
            state_q       <= state_d;
            s_ready_q     <= s_ready_d;
            imem_we_q     <= imem_we_d;
            imem_addr_q   <= imem_addr_d;
            imem_wdata_q  <= imem_wdata_d;
            cpu_reset_n_q <= cpu_reset_n_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
            fail_q        <= fail_d;
            word_cnt_q    <= word_cnt_d;
            len_q         <= len_d;
            exp_q         <= exp_d;
            cyc_q         <= cyc_d;
        end
    end

    assign s_ready     = s_ready_q;
    assign imem_we     = imem_we_q;
    assign imem_addr   = imem_addr_q;
    assign imem_wdata  = imem_wdata_q;
    assign cpu_reset_n = cpu_reset_n_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign fail        = fail_q;

endmodule

// File: tb/tb_mips_boot_controller.sv
// Bench for mips_boot_controller. It streams directed and random programs and
// checks each write and the run outcome against expectations built from
// handshake timing and simple run-length arithmetic.
module tb_mips_boot_controller;

    localparam int DW   = 32;
    localparam int AW   = 8;
    localparam int MAXW = 256;
    localparam int TO   = 1000;

    logic          clk = 1'b0;
    logic          reset, start, s_valid;
    logic [AW:0]   prog_len;
    logic [DW-1:0] expected, s_data, test_value;
    logic          s_ready, imem_we, cpu_reset_n, busy, done, pass, fail;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_wdata;

    mips_boot_controller #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_WORDS(MAXW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .prog_len(prog_len), .expected(expected),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .imem_we(imem_we),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_reset_n(cpu_reset_n),
        .test_value(test_value), .busy(busy), .done(done), .pass(pass), .fail(fail)
    );

    always #5 clk = ~clk;

    typedef struct {int c; logic [AW-1:0] a; logic [DW-1:0] d;} wr_t;
    wr_t           wlog[$];
    wr_t           wexp[$];
    int            cyc = 0;
    int            vectors = 0;
    int            miscompares = 0;
    int            last_edge = 0;
    logic [DW-1:0] prog [0:511];

    // Count clock edges so that write timing can be checked against handshake edges.
    always @(posedge clk) cyc <= cyc + 1;

    // Record every memory write, sampled away from the active edge.
    always @(negedge clk) if (imem_we === 1'b1) wlog.push_back('{cyc, imem_addr, imem_wdata});

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".s_ready"}, 64'(s_ready), 64'(0));
        chk({tag, ".imem_we"}, 64'(imem_we), 64'(0));
        chk({tag, ".imem_addr"}, 64'(imem_addr), 64'(0));
        chk({tag, ".imem_wdata"}, 64'(imem_wdata), 64'(0));
        chk({tag, ".cpu_reset_n"}, 64'(cpu_reset_n), 64'(0));
        chk({tag, ".busy"}, 64'(busy), 64'(0));
        chk({tag, ".done"}, 64'(done), 64'(0));
        chk({tag, ".pass"}, 64'(pass), 64'(0));
        chk({tag, ".fail"}, 64'(fail), 64'(0));
    endtask

    function automatic logic [DW-1:0] other(input logic [DW-1:0] e);
        logic [DW-1:0] v;
        v = $urandom;
        if (v == e) v = ~e;
        return v;
    endfunction

    task automatic do_start(input string tag, input int len, input logic [DW-1:0] e);
        wlog.delete();
        wexp.delete();
        start = 1'b1; prog_len = (AW+1)'(len); expected = e;
        test_value = e;  // a match while loading must have no effect
        @(posedge clk); #1;
        start = 1'b0; prog_len = (AW+1)'($urandom); expected = $urandom;
        chk({tag, ".start_busy"}, 64'(busy), 64'(1));
        chk({tag, ".start_ready"}, 64'(s_ready), 64'(1));
        chk({tag, ".start_flags"}, 64'({done, pass, fail, cpu_reset_n}), 64'(0));
    endtask

    // mode 0: back-to-back, 1: valid 1,0,0 repeating, 2: random gaps.
    task automatic load(input string tag, input int len, input int mode, input bit pulse, input int abort_after);
        int  hs, k;
        bit  v, take;
        hs = 0; k = 0;
        while (hs < len && k < 4 * len + 100) begin
            v = (mode == 0) ? 1'b1 : (mode == 1) ? (k % 3 == 0) : 1'($urandom_range(0, 1));
            s_valid = v;
            s_data  = v ? prog[hs] : $urandom;
            if (pulse && $urandom_range(0, 3) == 0) begin start = 1'b1; prog_len = '0; end
            take = v && (s_ready === 1'b1);
            @(posedge clk); #1;
            start = 1'b0; k++;
            if (take) begin
                wexp.push_back('{cyc, AW'(hs), prog[hs]});
                hs++;
                last_edge = cyc;
            end
            if (abort_after > 0 && hs == abort_after) break;
        end
        chk({tag, ".words_taken"}, 64'(hs), 64'((abort_after > 0) ? abort_after : len));
        if (abort_after == 0) begin
            chk({tag, ".ready_drop"}, 64'(s_ready), 64'(0));
            chk({tag, ".final_we"}, 64'(imem_we), 64'(1));
            // Offer one extra word. It must not be accepted.
            s_valid = 1'b1; s_data = $urandom;
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
    endtask

    task automatic verify_writes(input string tag);
        chk({tag, ".wcount"}, 64'(wlog.size()), 64'(wexp.size()));
        for (int i = 0; i < wexp.size() && i < wlog.size(); i++) begin
            chk({tag, ".wcycle"}, 64'(wlog[i].c), 64'(wexp[i].c));
            chk({tag, ".waddr"}, 64'(wlog[i].a), 64'(wexp[i].a));
            chk({tag, ".wdata"}, 64'(wlog[i].d), 64'(wexp[i].d));
        end
    endtask

    // match_at: run cycle (1-based) on which the stub shows the expected value; 0 = never.
    task automatic run_check(input string tag, input logic [DW-1:0] e, input int match_at, input bit pulse);
        int n, first, k, exp_n;
        bit exp_pass;
        n = 0; first = -1; k = 0;
        while (k < TO + 50) begin
            if (cpu_reset_n === 1'b1) begin
                n++;
                if (n == 1) first = cyc;
                test_value = (n == match_at) ? e : other(e);
                if (pulse && $urandom_range(0, 7) == 0) begin start = 1'b1; prog_len = (AW+1)'(1); end
            end else if (n > 0) begin
                break;
            end else begin
                test_value = other(e);
            end
            @(posedge clk); #1;
            start = 1'b0; k++;
        end
        exp_pass = (match_at >= 1 && match_at <= TO);
        exp_n    = exp_pass ? match_at : TO;
        chk({tag, ".run_start"}, 64'(first), 64'(last_edge + 1));
        chk({tag, ".run_len"}, 64'(n), 64'(exp_n));
        chk({tag, ".pass"}, 64'(pass), 64'(exp_pass));
        chk({tag, ".fail"}, 64'(fail), 64'(!exp_pass));
        chk({tag, ".done"}, 64'(done), 64'(1));
        chk({tag, ".busy"}, 64'(busy), 64'(0));
        chk({tag, ".cpu_rst"}, 64'(cpu_reset_n), 64'(0));
        repeat (3) @(posedge clk);
        #1;
        chk({tag, ".hold"}, 64'({done, pass, fail, busy, cpu_reset_n}), 64'({1'b1, exp_pass, !exp_pass, 2'b00}));
        verify_writes(tag);
    endtask

    task automatic bad_len(input string tag, input int len);
        wlog.delete();
        start = 1'b1; prog_len = (AW+1)'(len); expected = $urandom;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, ".flags"}, 64'({done, fail, pass, busy}), 64'(4'b1100));
        chk({tag, ".cpu_rst"}, 64'(cpu_reset_n), 64'(0));
        repeat (4) @(posedge clk);
        #1;
        chk({tag, ".no_write"}, 64'(wlog.size()), 64'(0));
        chk({tag, ".cpu_rst_hold"}, 64'(cpu_reset_n), 64'(0));
    endtask

    initial begin
        logic [DW-1:0] e;
        int            len, m;
        reset = 1'b1; start = 1'b0; prog_len = '0; expected = '0;
        s_valid = 1'b0; s_data = '0; test_value = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_idle("reset");
        reset = 1'b0;
        @(posedge clk); #1;
        chk_idle("idle");

        // Reference program, loaded back-to-back. The stub matches on run cycle 3.
        prog[0] = 32'h20080005; prog[1] = 32'h20090007;
        prog[2] = 32'h01095020; prog[3] = 32'hAC0A0000;
        do_start("b2b", 4, 32'd12);
        load("b2b", 4, 0, 1'b0, 0);
        run_check("b2b", 32'd12, 3, 1'b0);

        // The same program with valid toggling 1,0,0.
        do_start("gaps", 4, 32'd12);
        load("gaps", 4, 1, 1'b0, 0);
        run_check("gaps", 32'd12, 3, 1'b0);

        // The CPU never matches. Timeout occurs after exactly TIMEOUT run cycles.
        prog[0] = $urandom; prog[1] = $urandom;
        do_start("tmo", 2, 32'hDEADBEEF);
        load("tmo", 2, 2, 1'b0, 0);
        run_check("tmo", 32'hDEADBEEF, 0, 1'b0);

        // Illegal lengths.
        bad_len("len0", 0);
        bad_len("len_over", MAXW + 1);

        // Reset after two of four words. A new start reloads from address 0.
        for (int i = 0; i < 4; i++) prog[i] = $urandom;
        do_start("rst_mid", 4, 32'h5);
        load("rst_mid", 4, 0, 1'b0, 2);
        reset = 1'b1; s_valid = 1'b1; s_data = $urandom;
        @(posedge clk); #1;
        chk_idle("rst_mid.after");
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mid.ready", 64'(s_ready), 64'(0));
        s_valid = 1'b0;
        verify_writes("rst_mid");
        do_start("reload", 4, 32'h5);
        load("reload", 4, 2, 1'b0, 0);
        run_check("reload", 32'h5, 7, 1'b0);

        // Start pulses during LOAD and RUN. Match and timeout happen on the same cycle.
        for (int i = 0; i < 3; i++) prog[i] = $urandom;
        e = $urandom;
        do_start("both", 3, e);
        load("both", 3, 2, 1'b1, 0);
        run_check("both", e, TO, 1'b1);

        // Largest legal program.
        for (int i = 0; i < MAXW; i++) prog[i] = $urandom;
        e = $urandom;
        do_start("max", MAXW, e);
        load("max", MAXW, 2, 1'b0, 0);
        run_check("max", e, 1, 1'b0);

        // Random programs, gaps and match points.
        for (int t = 0; t < 5; t++) begin
            len = $urandom_range(1, 12);
            m   = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 40);
            e   = $urandom;
            for (int i = 0; i < len; i++) prog[i] = $urandom;
            do_start("rand", len, e);
            load("rand", len, 2, 1'($urandom_range(0, 1)), 0);
            run_check("rand", e, m, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mips_boot_controller.md
Name: mips_boot_controller

Overview:
- Program-load and run-control stage that sits directly upstream of the single-cycle MIPS top.
- Accepts a program as a valid/ready word stream and writes it into instruction memory through a write port.
- Then releases the CPU's active-low reset and watches the CPU's test_value output until it matches an expected value or a cycle budget expires.
- Reports busy/done/pass/fail for benches and for the board-level self-test.

Parameters:
DATA_WIDTH, 32, instruction/data word width
ADDR_WIDTH, 8, instruction-memory word-address width
MAX_WORDS, 256, largest legal program length (at most 2**ADDR_WIDTH)
TIMEOUT, 1000, maximum CPU run cycles before fail

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle request to begin load-and-run
prog_len  in  ADDR_WIDTH+1  program length in words, sampled on accepted start
expected  in  DATA_WIDTH  value test_value must reach for pass, sampled on accepted start
s_valid  in  1  program word valid
s_data  in  DATA_WIDTH  program word
s_ready  out  1  controller accepts a word this cycle
imem_we  out  1  instruction-memory write enable
imem_addr  out  ADDR_WIDTH  instruction-memory word address
imem_wdata  out  DATA_WIDTH  instruction-memory write data
cpu_reset_n  out  1  active-low reset driven to the MIPS top
test_value  in  DATA_WIDTH  observation output of the MIPS top
busy  out  1  high in LOAD and RUN
done  out  1  high in DONE
pass  out  1  run matched expected
fail  out  1  timeout or illegal length

Behaviour:
- All outputs are registered.
- Reset, taking effect at the next clk edge with reset high:
  - state=IDLE.
  - s_ready=0, imem_we=0, imem_addr=0, imem_wdata=0.
  - cpu_reset_n=0, busy=0, done=0, pass=0, fail=0.
  - Internal word and cycle counters=0.
  - Instruction-memory contents are untouched.
- Reset asserted in any state (mid-load or mid-run) aborts immediately with the same values. No partial write is issued after the reset edge.
- States: IDLE, LOAD, RUN, DONE.
- IDLE or DONE, start=1:
  - Clear pass/fail/done and sample prog_len and expected.
  - If 1 <= prog_len <= MAX_WORDS: word counter=0 and go to LOAD.
  - Otherwise (0 or >MAX_WORDS): fail=1, done=1, go to DONE. No memory write occurs and cpu_reset_n stays 0.
- start is ignored in LOAD and RUN.
- LOAD:
  - s_ready=1 and busy=1; cpu_reset_n held 0.
  - A word transfers on the cycle where s_valid and s_ready are both high.
  - One cycle after each transfer: imem_we=1, imem_addr=word index (0,1,2,...), imem_wdata=accepted word. Otherwise imem_we=0.
  - Gaps in s_valid are allowed; s_data is ignored when no transfer occurs.
  - On the cycle the last word (index prog_len-1) transfers, s_ready drops to 0 at the next edge, coincident with the final imem_we pulse. No extra word is accepted.
  - The state moves to RUN on the cycle after the final write.
- RUN:
  - cpu_reset_n=1, busy=1. The cycle counter increments each cycle, starting at 1 on the first RUN cycle.
  - Each cycle compare test_value to expected.
  - On match: pass=1, done=1, cpu_reset_n=0, go to DONE.
  - Else if counter == TIMEOUT: fail=1, done=1, cpu_reset_n=0, go to DONE.
  - If a match and timeout occur in the same cycle, pass wins.
- DONE:
  - Hold pass/fail/done with cpu_reset_n=0 and busy=0 until start or reset.
  - pass and fail are never both 1.
- Widths:
  - Word counter is ADDR_WIDTH+1 bits, so prog_len=MAX_WORDS=2**ADDR_WIDTH writes addresses 0..MAX_WORDS-1 without wrap.
  - Cycle counter is wide enough for TIMEOUT and saturates, never wraps.

Test Plan:
- Load 4 words 0x20080005, 0x20090007, 0x01095020, 0xAC0A0000 back-to-back with prog_len=4 -> imem_we pulses at addresses 0..3 with the matching data, each one cycle after its handshake; s_ready low after the 4th; RUN with cpu_reset_n=1. A stub drives test_value=12 on run cycle 3 with expected=12 -> pass=1, done=1, cpu_reset_n=0, busy=0.
- Same load with s_valid toggling 1,0,0,1,... -> writes occur only after handshakes, addresses contiguous 0..3, no duplicate or skipped write.
- prog_len=2, expected=0xDEADBEEF, test_value never matches, TIMEOUT=1000 -> fail=1 exactly on run cycle 1000, pass=0.
- start with prog_len=0, and separately prog_len=MAX_WORDS+1 -> fail=1, done=1 on the next cycle; imem_we never asserts; cpu_reset_n stays 0.
- reset=1 after 2 of 4 words accepted -> next edge: all outputs at reset values, no further imem_we. A new start reloads from address 0.
- start pulsed during LOAD and RUN -> ignored, sequence unaffected. Match and timeout on the same cycle -> pass=1, fail=0.
